// File: rtl/qpsk_tx_pkg.sv
// Shared types and constants for the DQPSK transmit mapper: FSM states, phase/sample
// types and the Gray-coded dibit to phase-increment mapping.
package qpsk_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REF    = 2'd1,
    SYMBOL = 2'd2
  } state_t;

  typedef logic [1:0]         phase_t;
  typedef logic signed [15:0] sample_t;

  // Gray-coded dibit to quarter-turn increment
  localparam phase_t INC_00 = 2'd0;
  localparam phase_t INC_01 = 2'd1;
  localparam phase_t INC_11 = 2'd2;
  localparam phase_t INC_10 = 2'd3;

  function automatic phase_t dibit_inc(input logic [1:0] dibit);
    phase_t inc;
    case (dibit)
      2'b00:   inc = INC_00;
      2'b01:   inc = INC_01;
      2'b11:   inc = INC_11;
      default: inc = INC_10;
    endcase
    return inc;
  endfunction

  // Dibits are consumed MSB first: idx 0 is [7:6], idx 3 is [1:0]
  function automatic logic [1:0] dibit_at(input logic [7:0] byte_dat, input logic [1:0] idx);
    logic [1:0] d;
    case (idx)
      2'd0:    d = byte_dat[7:6];
      2'd1:    d = byte_dat[5:4];
      2'd2:    d = byte_dat[3:2];
      default: d = byte_dat[1:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dqpsk_symbol_mapper_phase_to_iq.sv
// Combinational phase to {I, Q} lookup; one axis carries +/-amplitude, the other zero.
// Zero latency, no flow control; the parent registers the result.
module phase_to_iq
  import qpsk_tx_pkg::*;
(
  input  phase_t      phase,
  input  sample_t     amplitude,
  output logic [31:0] iq_dat
);

  sample_t i_s;
  sample_t q_s;
  sample_t neg_amp;

  always_comb begin
    neg_amp = -amplitude;
    i_s     = '0;
    q_s     = '0;
    case (phase)
      2'd0:    i_s = amplitude;
      2'd1:    q_s = amplitude;
      2'd2:    i_s = neg_amp;
      default: q_s = neg_amp;
    endcase
    iq_dat = {i_s, q_s};
  end

endmodule

// File: rtl/dqpsk_symbol_mapper.sv
// Byte stream to differentially encoded QPSK {I,Q} samples; first sample one clock after accept.
// Counters advance only on m00 handshakes; output holds stable while stalled, input idles while busy.
module dqpsk_symbol_mapper
  import qpsk_tx_pkg::*;
#(
  parameter int      C_S00_AXIS_TDATA_WIDTH = 8,
  parameter int      C_M00_AXIS_TDATA_WIDTH = 32,
  parameter sample_t AMPLITUDE              = 16'sd23170,
  parameter int      SAMPLES_PER_SYMBOL     = 8
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  input  logic                              s00_axis_tstrb,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  output logic [3:0]                        m00_axis_tstrb
);

  localparam int CNT_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(SAMPLES_PER_SYMBOL - 1);

  state_t                            state_q, state_d;
  phase_t                            phase_q, phase_d;
  logic                              first_q, first_d;
  logic [7:0]                        byte_q, byte_d;
  logic                              last_q, last_d;
  logic [1:0]                        dibit_q, dibit_d;
  logic [CNT_W-1:0]                  samp_q, samp_d;
  logic                              s_rdy_q, s_rdy_d;
  logic                              m_vld_q, m_vld_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_dat_q, m_dat_d;
  logic                              m_last_q, m_last_d;

  logic        s_hs;
  logic        m_hs;
  logic        sym_end;
  logic [31:0] iq_dat;
  logic        unused_tstrb;

  assign unused_tstrb = s00_axis_tstrb;

  // Driven from the next phase so a freshly entered symbol is emitted on its first beat
  phase_to_iq u_phase_to_iq (
    .phase     (phase_d),
    .amplitude (AMPLITUDE),
    .iq_dat    (iq_dat)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    first_d  = first_q;
    byte_d   = byte_q;
    last_d   = last_q;
    dibit_d  = dibit_q;
    samp_d   = samp_q;
    s_rdy_d  = s_rdy_q;
    m_vld_d  = m_vld_q;
    m_dat_d  = m_dat_q;
    m_last_d = 1'b0;

    s_hs    = (state_q == IDLE) && s_rdy_q && s00_axis_tvalid;
    m_hs    = m_vld_q && m00_axis_tready;
    sym_end = (samp_q == LAST_SAMP);

    case (state_q)
      IDLE: begin
        s_rdy_d = 1'b1;
        if (s_hs) begin
          byte_d  = s00_axis_tdata[7:0];
          last_d  = s00_axis_tlast;
          s_rdy_d = 1'b0;
          m_vld_d = 1'b1;
          samp_d  = '0;
          dibit_d = 2'd0;
          if (first_q) begin
            state_d = REF;
          end else begin
            state_d = SYMBOL;
            phase_d = phase_q + dibit_inc(s00_axis_tdata[7:6]);
          end
        end
      end

      REF: begin
        if (m_hs) begin
          if (sym_end) begin
            state_d = SYMBOL;
            first_d = 1'b0;
            samp_d  = '0;
            dibit_d = 2'd0;
            phase_d = phase_q + dibit_inc(dibit_at(byte_q, 2'd0));
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end

      SYMBOL: begin
        if (m_hs) begin
          if (sym_end && (dibit_q == 2'd3)) begin
            state_d = IDLE;
            m_vld_d = 1'b0;
            s_rdy_d = 1'b1;
            if (last_q) begin
              first_d = 1'b1;
            end
          end else if (sym_end) begin
            dibit_d = dibit_q + 2'd1;
            samp_d  = '0;
            phase_d = phase_q + dibit_inc(dibit_at(byte_q, 2'(dibit_q + 2'd1)));
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        m_vld_d = 1'b0;
      end
    endcase

    if (m_vld_d) begin
      m_dat_d = iq_dat;
    end
    // Final beat of the final dibit of a tlast byte
    m_last_d = m_vld_d && last_d && (state_d == SYMBOL) &&
               (dibit_d == 2'd3) && (samp_d == LAST_SAMP);
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      first_q  <= 1'b1;
      byte_q   <= '0;
      last_q   <= 1'b0;
      dibit_q  <= '0;
      samp_q   <= '0;
      s_rdy_q  <= 1'b0;
      m_vld_q  <= 1'b0;
      m_dat_q  <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      first_q  <= first_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      dibit_q  <= dibit_d;
      samp_q   <= samp_d;
      s_rdy_q  <= s_rdy_d;
      m_vld_q  <= m_vld_d;
      m_dat_q  <= m_dat_d;
      m_last_q <= m_last_d;
    end
  end

  assign s00_axis_tready = s_rdy_q;
  assign m00_axis_tvalid = m_vld_q;
  assign m00_axis_tdata  = m_dat_q;
  assign m00_axis_tlast  = m_last_q;
  assign m00_axis_tstrb  = 4'hF;

endmodule

// File: tb/tb_dqpsk_symbol_mapper.sv
// Directed bench for dqpsk_symbol_mapper: hand-computed sample sequences per scenario.
module tb_dqpsk_symbol_mapper;

  localparam int SPS = 8;
  localparam logic [31:0] P0 = 32'h5A820000;
  localparam logic [31:0] P1 = 32'h00005A82;
  localparam logic [31:0] P2 = 32'hA57E0000;
  localparam logic [31:0] P3 = 32'h0000A57E;

  logic        clk;
  logic        rst;
  logic        s_vld;
  logic        s_rdy;
  logic [7:0]  s_dat;
  logic        s_last;
  logic        s_strb;
  logic        m_vld;
  logic        m_rdy;
  logic [31:0] m_dat;
  logic        m_last;
  logic [3:0]  m_strb;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  logic [31:0] cap_dat  [0:127];
  logic        cap_last [0:127];
  int          cap_hs   [0:127];
  logic [31:0] exp_dat  [0:127];
  logic        exp_last [0:127];
  int          exp_n;

  dqpsk_symbol_mapper #(
    .C_S00_AXIS_TDATA_WIDTH (8),
    .C_M00_AXIS_TDATA_WIDTH (32),
    .AMPLITUDE              (16'sd23170),
    .SAMPLES_PER_SYMBOL     (SPS)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_vld),
    .s00_axis_tready (s_rdy),
    .s00_axis_tdata  (s_dat),
    .s00_axis_tlast  (s_last),
    .s00_axis_tstrb  (s_strb),
    .m00_axis_tvalid (m_vld),
    .m00_axis_tready (m_rdy),
    .m00_axis_tdata  (m_dat),
    .m00_axis_tlast  (m_last),
    .m00_axis_tstrb  (m_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_vld && s_rdy) hs_cnt <= hs_cnt + 1;
  end

  task automatic exp_clear();
    exp_n = 0;
  endtask

  task automatic exp_sym(input logic [31:0] w);
    for (int k = 0; k < SPS; k++) begin
      exp_dat[exp_n]  = w;
      exp_last[exp_n] = 1'b0;
      exp_n++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, output bit to);
    int cnt;
    cnt    = 0;
    s_dat  = b;
    s_last = l;
    s_vld  = 1'b1;
    while (!s_rdy && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    to = !s_rdy;
    @(negedge clk);
    s_vld = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high one cycle in three
  task automatic collect(input int n, input int mode, output int got, output int stall_bad,
                         output int overlap, output bit to);
    logic [31:0] held_dat;
    logic        held_last;
    bit          held;
    int          cyc;
    held = 0; cyc = 0; got = 0; stall_bad = 0; overlap = 0;
    held_dat = '0; held_last = 1'b0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (held && (m_vld !== 1'b1 || m_dat !== held_dat || m_last !== held_last)) stall_bad++;
      m_rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (m_vld && s_rdy) overlap++;
      if (m_vld && m_rdy) begin
        cap_dat[got]  = m_dat;
        cap_last[got] = m_last;
        cap_hs[got]   = hs_cnt;
        got++;
        held = 0;
      end else if (m_vld) begin
        held      = 1;
        held_dat  = m_dat;
        held_last = m_last;
      end else begin
        held = 0;
      end
    end
    m_rdy = 1'b1;
    to = (got < n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (m_vld !== 1'b0 || s_rdy !== 1'b0 || m_dat !== 32'h0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b rdy=%b dat=%h last=%b want 0/0/0/0", m_vld, s_rdy, m_dat, m_last);
    end
    checks++;
    if (m_strb !== 4'hF) begin
      errors++;
      $display("FAIL tstrb got %h want f", m_strb);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (s_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rdy_before_edge got %b want 0", s_rdy);
    end
    @(negedge clk);
    checks++;
    if (s_rdy !== 1'b1 || m_vld !== 1'b0) begin
      errors++;
      $display("FAIL rdy_after_release got rdy=%b vld=%b want 1/0", s_rdy, m_vld);
    end
  endtask

  task automatic test_single_byte(input int mode);
    int got, sb, ov;
    bit to_s, to_c;
    do_reset();
    exp_clear();
    exp_sym(P0); exp_sym(P0); exp_sym(P1); exp_sym(P0); exp_sym(P2);
    exp_last[39] = 1'b1;
    fork
      send_byte(8'h1B, 1'b1, to_s);
      collect(40, mode, got, sb, ov, to_c);
    join
    checks++;
    if (to_s || to_c || got != 40) begin
      errors++;
      $display("FAIL single_count mode=%0d got %0d samples want 40", mode, got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL single_m%0d_s%0d got %h/%b want %h/%b", mode, i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
      end
    end
    checks++;
    if (sb != 0 || ov != 0) begin
      errors++;
      $display("FAIL single_stall mode=%0d got unstable=%0d overlap=%0d want 0/0", mode, sb, ov);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (m_vld !== 1'b0 || s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL single_extra got vld=%b rdy=%b want 0/1", m_vld, s_rdy);
    end
  endtask

  task automatic test_two_bytes();
    int got, sb, ov;
    bit to_a, to_b, to_c;
    do_reset();
    exp_clear();
    exp_sym(P0); exp_sym(P1); exp_sym(P2); exp_sym(P3); exp_sym(P0);
    exp_sym(P0); exp_sym(P0); exp_sym(P0); exp_sym(P0);
    exp_last[71] = 1'b1;
    fork
      begin
        send_byte(8'h55, 1'b0, to_a);
        send_byte(8'h00, 1'b1, to_b);
      end
      collect(72, 0, got, sb, ov, to_c);
    join
    checks++;
    if (to_a || to_b || to_c || got != 72) begin
      errors++;
      $display("FAIL two_count got %0d samples want 72", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL two_s%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
      end
    end
    checks++;
    if (ov != 0) begin
      errors++;
      $display("FAIL two_rdy_busy got %0d cycles with tready during output want 0", ov);
    end
  endtask

  task automatic test_packet_continuity();
    int got, sb, ov;
    bit to_a, to_b, to_c;
    do_reset();
    exp_clear();
    exp_sym(P0); exp_sym(P1); exp_sym(P1); exp_sym(P1); exp_sym(P1);
    exp_sym(P1); exp_sym(P3); exp_sym(P1); exp_sym(P3); exp_sym(P1);
    exp_last[39] = 1'b1;
    exp_last[79] = 1'b1;
    fork
      begin
        send_byte(8'h40, 1'b1, to_a);
        send_byte(8'hFF, 1'b1, to_b);
      end
      collect(80, 0, got, sb, ov, to_c);
    join
    checks++;
    if (to_a || to_b || to_c || got != 80) begin
      errors++;
      $display("FAIL pkt_count got %0d samples want 80", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL pkt_s%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int got, sb, ov;
    bit to_a, to_b, to_c;
    do_reset();
    fork
      begin
        send_byte(8'h40, 1'b1, to_a);
        send_byte(8'h00, 1'b1, to_b);
      end
      collect(44, 0, got, sb, ov, to_c);
    join
    checks++;
    if (to_a || to_b || to_c || got != 44 || cap_dat[40] !== P1) begin
      errors++;
      $display("FAIL midrst_pre got %0d samples ref=%h want 44 / %h", got, cap_dat[40], P1);
    end
    @(negedge clk);
    checks++;
    if (m_vld !== 1'b1 || m_dat !== P1) begin
      errors++;
      $display("FAIL midrst_ref5 got vld=%b dat=%h want 1/%h", m_vld, m_dat, P1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_vld !== 1'b0 || s_rdy !== 1'b0 || m_dat !== 32'h0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got vld=%b rdy=%b dat=%h last=%b want 0/0/0/0", m_vld, s_rdy, m_dat, m_last);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_rdy !== 1'b1 || m_vld !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release got rdy=%b vld=%b want 1/0", s_rdy, m_vld);
    end
    exp_clear();
    for (int k = 0; k < 5; k++) exp_sym(P0);
    exp_last[39] = 1'b1;
    fork
      send_byte(8'h00, 1'b1, to_a);
      collect(40, 0, got, sb, ov, to_c);
    join
    checks++;
    if (to_a || to_c || got != 40) begin
      errors++;
      $display("FAIL midrst_count got %0d samples want 40", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL midrst_s%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got, sb, ov, base;
    bit to_a, to_b, to_c;
    do_reset();
    base = hs_cnt;
    exp_clear();
    exp_sym(P0); exp_sym(P2); exp_sym(P2); exp_sym(P2); exp_sym(P2);
    for (int k = 0; k < 5; k++) exp_sym(P2);
    exp_last[39] = 1'b1;
    exp_last[79] = 1'b1;
    fork
      begin
        send_byte(8'hC0, 1'b1, to_a);
        send_byte(8'h00, 1'b1, to_b);
      end
      collect(80, 1, got, sb, ov, to_c);
    join
    checks++;
    if (to_a || to_b || to_c || got != 80) begin
      errors++;
      $display("FAIL b2b_count got %0d samples want 80", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL b2b_s%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
      end
    end
    checks++;
    if (cap_hs[39] - base != 1 || cap_hs[40] - base != 2) begin
      errors++;
      $display("FAIL b2b_handshakes got %0d then %0d want 1 then 2", cap_hs[39] - base, cap_hs[40] - base);
    end
    checks++;
    if (sb != 0 || ov != 0) begin
      errors++;
      $display("FAIL b2b_stall got unstable=%0d overlap=%0d want 0/0", sb, ov);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (hs_cnt - base != 2) begin
      errors++;
      $display("FAIL b2b_total_hs got %0d want 2", hs_cnt - base);
    end
  endtask

  initial begin
    rst    = 1'b1;
    s_vld  = 1'b0;
    s_dat  = 8'h00;
    s_last = 1'b0;
    s_strb = 1'b1;
    m_rdy  = 1'b1;
    test_reset();
    test_single_byte(0);
    test_single_byte(1);
    test_two_bytes();
    test_packet_continuity();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dqpsk_symbol_mapper.md
Name: dqpsk_symbol_mapper

Overview:
- Transmit-side counterpart of the phase-detect path: turns an AXI-Stream byte stream into differentially encoded QPSK I/Q samples.
- Each Gray-coded dibit rotates the carrier phase by a multiple of 90°, so the receiver recovers data from the angle between consecutive symbols.
- Each symbol is held for SAMPLES_PER_SYMBOL output samples.
- Output drives the DAC/upsampler chain over AXI-Stream, I in [31:16] and Q in [15:0].

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 8: input byte width. Fixed at 8.
- C_M00_AXIS_TDATA_WIDTH, 32: output sample width, packed {I[15:0], Q[15:0]}, both signed.
- AMPLITUDE, 16'sd23170 (0x5A82): magnitude of the non-zero axis component.
- SAMPLES_PER_SYMBOL, 8: output beats per symbol. Must be ≥1.

Ports:
- s00_axis_aclk, in, 1: the single clock for both AXIS interfaces.
- s00_axis_areset, in, 1: asynchronous, active-high reset.
- s00_axis_tvalid, in, 1: input byte valid.
- s00_axis_tready, out, 1: mapper can accept a byte.
- s00_axis_tdata, in, 8: data byte; dibits are consumed MSB first ([7:6], [5:4], [3:2], [1:0]).
- s00_axis_tlast, in, 1: byte is the last of its packet.
- s00_axis_tstrb, in, 1: ignored.
- m00_axis_tvalid, out, 1: sample valid.
- m00_axis_tready, in, 1: downstream accepts the sample.
- m00_axis_tdata, out, 32: {I, Q} sample.
- m00_axis_tlast, out, 1: last sample of the packet.
- m00_axis_tstrb, out, 4: constant 4'hF.

Behaviour:
- Reset (async assert, sync release):
  - Output reset values: s00_axis_tready=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0.
  - Internal reset values: phase=0, first_of_packet=1, state=IDLE.
  - s00_axis_tready rises on the first clock edge after release.
- Phase map (2-bit phase p):
  - p=0 → (+A, 0)
  - p=1 → (0, +A)
  - p=2 → (−A, 0)
  - p=3 → (0, −A)
  - −A is the two's complement of AMPLITUDE.
- Dibit increment (Gray code): 00→+0, 01→+1, 11→+2, 10→+3. Phase addition is mod 4 and wraps naturally.
- States: IDLE, REF, SYMBOL.
- IDLE:
  - s00_axis_tready=1 and m00_axis_tvalid=0.
  - On s00 handshake, latch the byte and its tlast, and drop tready.
  - If first_of_packet=1, go to REF; otherwise go to SYMBOL with the first dibit.
- REF:
  - Emits SAMPLES_PER_SYMBOL samples at the current phase, with no phase change. This gives the receiver its reference.
  - Then clears first_of_packet and goes to SYMBOL.
- SYMBOL:
  - On entry to each dibit, phase <= phase + inc(dibit). The samples carry the new phase.
  - Emits SAMPLES_PER_SYMBOL samples per dibit, then the next dibit.
  - After dibit 3, returns to IDLE.
  - If the latched tlast=1, set first_of_packet=1.
- Latency: the first output sample is valid on the cycle after the s00 handshake, so m00_axis_tvalid rises 1 clock after acceptance.
- Sample/dibit counters advance only on an m00 handshake (tvalid && tready).
- While stalled, tdata and tlast hold stable.
- Between sample beats inside a byte, tvalid stays continuously high with no bubbles.
- One idle cycle (IDLE) separates bytes. Full-rate input is not required.
- Output counts:
  - m00_axis_tlast=1 only on the final sample of dibit 3 of a byte latched with tlast=1.
  - A first byte of a packet produces 5×SPS samples; any other byte produces 4×SPS.
- Phase is continuous across packets and is never reset except by s00_axis_areset.
- While busy, s00_axis_tvalid is ignored and no byte is consumed.
- Reset mid-operation: all outputs take their reset values immediately (async). The partial symbol and byte are discarded.

Decomposition:
- Package qpsk_tx_pkg holds:
  - state enum {IDLE, REF, SYMBOL}
  - dibit→increment constants
  - sample_t (signed 16-bit)
  - the 2-bit phase_t type
- One sub-module, phase_to_iq: combinational, phase_t and AMPLITUDE in, {I, Q} out. It is registered by the parent into m00_axis_tdata.

Test Plan:
1. Reset, byte 0x1B with tlast=1, tready=1 throughout → 40 samples:
   - 8×0x5A820000 (REF, p0)
   - 8×0x5A820000 (dibit 00, p0)
   - 8×0x00005A82 (dibit 01, p1)
   - 8×0x5A820000 (dibit 10, p0)
   - 8×0xA57E0000 (dibit 11, p2)
   - tlast only on sample 40.
2. Same stimulus as 1 with m00_axis_tready high 1 cycle in 3 → identical 40-sample sequence; tdata/tlast stable across every stall; no dropped or duplicated beats.
3. Bytes 0x55 (tlast=0) then 0x00 (tlast=1) → one REF (8×p0), then p1, p2, p3, p0, then 4×p0. 72 samples total, tlast on sample 72 only, tready low during both bytes.
4. Packet 0x40 with tlast=1 (ends at p1), then packet 0xFF with tlast=1 → second packet's REF = 8×0x00005A82, then phases p3, p1, p3, p1 (0x0000A57E / 0x00005A82).
5. Assert s00_axis_areset during REF sample 5 → tvalid=0 and tready=0 asynchronously. After release, byte 0x00 with tlast=1 → REF at p0 (0x5A820000), 40 samples.
6. s00_axis_tvalid held high with a new byte during a busy byte → no acceptance until IDLE; exactly one s00 handshake per byte; 0xC0 yields dibit 11 → p2 after REF.
